trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter TRAP_CNT_W, default 16, width of the retired-trap counter.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_i  in  1  current decoded instruction is valid.
REQ-005 SHALL have port pc_i  in  32  PC of the current instruction.
REQ-006 SHALL have port instr_i  in  32  raw current instruction word.
REQ-007 SHALL have port exc_flags_i  in  exc_flags_t  fetch_mis, illegal, ebreak, load_mis, store_mis, ecall.
REQ-008 SHALL have port mem_addr_i  in  32  faulting data address for load/store misaligned.
REQ-009 SHALL have port mret_i  in  1  current instruction is MRET.
REQ-010 SHALL have port mtime_exc_i  in  1  gated timer interrupt from the CSR unit.
REQ-011 SHALL have port mtvec_i, mepc_i  in  32 each  trap vector and return PC from the CSR unit.
REQ-012 SHALL have port exc_request_o, exc_cause_o, trap_info_o, exc_pc_o  out  1/32/32/32  trap request to the CSR unit.
REQ-013 SHALL have port pc_redirect_o  out  1  and pc_target_o  out  32  fetch redirect.
REQ-014 SHALL have port stall_o  out  1,  flush_o  out  1,  fatal_o  out  1,  trap_cnt_o  out  TRAP_CNT_W.

Function
REQ-015 SHALL implement FSM states IDLE, TRAP_REQ, TRAP_JUMP, MRET_JUMP, HALT.
REQ-016 In IDLE, an accepted event SHALL be latched into cause/pc/info registers, and the FSM SHALL move to TRAP_REQ on the next edge.
- Accepted event: mtime_exc_i, or valid_i with any exc flag set.
REQ-017 Event priority, highest first, SHALL be:
- timer (M_TIMER_INT)
- fetch_mis (0)
- illegal (2)
- ebreak (3)
- load_mis (4)
- store_mis (6)
- ecall (11)
REQ-018 trap_info latch SHALL be:
- pc_i for fetch_mis and ebreak
- instr_i for illegal
- mem_addr_i for load_mis and store_mis
- 0 for ecall and timer
REQ-019 TRAP_REQ SHALL last exactly 1 cycle with exc_request_o=1, flush_o=1, stall_o=1, and latched values on exc_cause_o/exc_pc_o/trap_info_o.
REQ-020 TRAP_JUMP SHALL last exactly 1 cycle with pc_redirect_o=1, pc_target_o=mtvec_i, stall_o=1; the FSM then returns to IDLE.
REQ-021 Trap latency: event cycle N -> exc_request_o at N+1 -> redirect at N+2 -> IDLE at N+3.
REQ-022 MRET handling:
- In IDLE, valid_i&mret_i with no other event SHALL go to MRET_JUMP.
- MRET_JUMP lasts 1 cycle with pc_redirect_o=1, pc_target_o=mepc_i, flush_o=1, stall_o=1.
- MRET_JUMP clears in_trap.
REQ-023 in_trap SHALL set on entry to TRAP_REQ and clear on MRET_JUMP.
REQ-024 Timer interrupts SHALL be ignored while in_trap=1.
REQ-025 A synchronous exception while in_trap=1 SHALL go to HALT. HALT is terminal until reset, with fatal_o=1, stall_o=1 and all request outputs 0.
REQ-026 Simultaneous events SHALL resolve as follows:
- An interrupt or exception concurrent with mret_i wins; the MRET is discarded and exc_pc_o equals its PC.
- All inputs SHALL be ignored in TRAP_REQ, TRAP_JUMP and MRET_JUMP.
REQ-027 trap_cnt_o SHALL increment by 1 on each TRAP_REQ cycle and wrap modulo 2^TRAP_CNT_W.
REQ-028 Outputs not driven per state SHALL be 0, except exc_cause_o/exc_pc_o/trap_info_o, which hold their latched values.

Reset
REQ-029 rst=0 SHALL asynchronously force:
- FSM=IDLE, in_trap=0, trap_cnt_o=0
- all latched registers and all outputs to 0
REQ-030 Reset asserted in any state, including HALT or mid-sequence, SHALL abort the sequence with no redirect issued after release.

Structure
REQ-031 exc_flags_t, the state enum, cause codes (incl. M_TIMER_INT) and the priority order SHALL live in riscV_unrn_pkg.
REQ-032 The priority encoder SHALL be one sub-module, trap_prio_enc, mapping flags+timer to {hit, cause, info_sel}.

Verification
REQ-033 Illegal instr: valid_i=1, illegal=1, pc_i=0x100, instr_i=0xFFFFFFFF, mtvec_i=0x200 -> N+1: exc_request_o=1, cause 2, info 0xFFFFFFFF, exc_pc 0x100; N+2: redirect to 0x200.
REQ-034 Timer with ecall: mtime_exc_i=1 and ecall=1 at same cycle -> cause M_TIMER_INT, info 0; trap_cnt_o increments once.
REQ-035 MRET: after a trap, mret_i=1, mepc_i=0x104 -> next cycle redirect to 0x104, flush_o=1; a following timer trap is accepted.
REQ-036 Nested fault: after a trap and before MRET, load_mis=1 -> HALT, fatal_o=1 stays until rst=0; an mtime_exc_i pulse before the load_mis is ignored.
REQ-037 Reset mid-sequence: rst=0 during TRAP_REQ -> outputs 0 immediately, no redirect after release; trap_cnt_o wraps from 0xFFFF to 0 on the next trap.

Source files
------------

// File: rtl/riscV_unrn_pkg.sv
// Shared types, cause codes and trap priority order for the trap sequencer.
package riscV_unrn_pkg;

  localparam int unsigned XLEN = 32;

  // Synchronous exception flags raised by decode/execute for the current instruction
  typedef struct packed {
    logic fetch_mis;
    logic illegal;
    logic ebreak;
    logic load_mis;
    logic store_mis;
    logic ecall;
  } exc_flags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRAP_REQ,
    ST_TRAP_JUMP,
    ST_MRET_JUMP,
    ST_HALT
  } state_t;

  // Which source feeds the latched trap_info value
  typedef enum logic [1:0] {
    INFO_ZERO,
    INFO_PC,
    INFO_INSTR,
    INFO_ADDR
  } info_sel_t;

  localparam logic [XLEN-1:0] CAUSE_FETCH_MIS = 32'd0;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL   = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_EBREAK    = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_LOAD_MIS  = 32'd4;
  localparam logic [XLEN-1:0] CAUSE_STORE_MIS = 32'd6;
  localparam logic [XLEN-1:0] CAUSE_ECALL     = 32'd11;
  localparam logic [XLEN-1:0] M_TIMER_INT     = 32'h8000_0007;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] cause;
    info_sel_t       info_sel;
  } prio_t;

  // Trap priority, highest first: timer, fetch_mis, illegal, ebreak, load_mis, store_mis, ecall
  function automatic prio_t trap_prio(input exc_flags_t flags, input logic timer);
    prio_t p;
    p.hit      = 1'b1;
    p.cause    = '0;
    p.info_sel = INFO_ZERO;
    if (timer) begin
      p.cause = M_TIMER_INT;
    end else if (flags.fetch_mis) begin
      p.cause    = CAUSE_FETCH_MIS;
      p.info_sel = INFO_PC;
    end else if (flags.illegal) begin
      p.cause    = CAUSE_ILLEGAL;
      p.info_sel = INFO_INSTR;
    end else if (flags.ebreak) begin
      p.cause    = CAUSE_EBREAK;
      p.info_sel = INFO_PC;
    end else if (flags.load_mis) begin
      p.cause    = CAUSE_LOAD_MIS;
      p.info_sel = INFO_ADDR;
    end else if (flags.store_mis) begin
      p.cause    = CAUSE_STORE_MIS;
      p.info_sel = INFO_ADDR;
    end else if (flags.ecall) begin
      p.cause = CAUSE_ECALL;
    end else begin
      p.hit = 1'b0;
    end
    return p;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Combinational priority encoder: qualified flags + timer -> {hit, cause, info_sel}.
module trap_prio_enc
  import riscV_unrn_pkg::*;
(
  input  exc_flags_t      flags,
  input  logic            timer,
  output logic            hit_c,
  output logic [XLEN-1:0] cause_c,
  output info_sel_t       info_sel_c
);

  prio_t pick;

  // Resolve the highest-priority pending event
  always_comb begin
    pick       = trap_prio(flags, timer);
    hit_c      = pick.hit;
    cause_c    = pick.cause;
    info_sel_c = pick.info_sel;
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: latches trap events, requests the CSR update,
// redirects fetch to mtvec/mepc and halts on a fault taken inside a handler.
module trap_sequencer
  import riscV_unrn_pkg::*;
#(
  parameter int unsigned TRAP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [XLEN-1:0]       instr_i,
  input  exc_flags_t            exc_flags_i,
  input  logic [XLEN-1:0]       mem_addr_i,
  input  logic                  mret_i,
  input  logic                  mtime_exc_i,
  input  logic [XLEN-1:0]       mtvec_i,
  input  logic [XLEN-1:0]       mepc_i,
  output logic                  exc_request_o,
  output logic [XLEN-1:0]       exc_cause_o,
  output logic [XLEN-1:0]       trap_info_o,
  output logic [XLEN-1:0]       exc_pc_o,
  output logic                  pc_redirect_o,
  output logic [XLEN-1:0]       pc_target_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  fatal_o,
  output logic [TRAP_CNT_W-1:0] trap_cnt_o
);

  state_t          state_q;
  state_t          state_d;
  logic            in_trap_q;
  logic            sync_hit_c;
  logic            timer_c;
  exc_flags_t      flags_c;
  logic            enc_hit_c;
  logic [XLEN-1:0] enc_cause_c;
  info_sel_t       enc_info_sel_c;
  logic [XLEN-1:0] info_c;
  logic            accept_c;

  logic            req_d;
  logic            redirect_d;
  logic [XLEN-1:0] target_d;
  logic            stall_d;
  logic            flush_d;
  logic            fatal_d;

  // Qualify event sources; timer is masked while a handler is running
  always_comb begin
    flags_c    = valid_i ? exc_flags_i : '0;
    sync_hit_c = |flags_c;
    timer_c    = mtime_exc_i & ~in_trap_q;
  end

  trap_prio_enc u_prio (
    .flags      (flags_c),
    .timer      (timer_c),
    .hit_c      (enc_hit_c),
    .cause_c    (enc_cause_c),
    .info_sel_c (enc_info_sel_c)
  );

  // Select the trap_info value for the winning event
  always_comb begin
    info_c = '0;
    case (enc_info_sel_c)
      INFO_PC:    info_c = pc_i;
      INFO_INSTR: info_c = instr_i;
      INFO_ADDR:  info_c = mem_addr_i;
      default:    info_c = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; only IDLE looks at inputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_trap_q && sync_hit_c)    state_d = ST_HALT;
        else if (enc_hit_c)             state_d = ST_TRAP_REQ;
        else if (valid_i && mret_i)     state_d = ST_MRET_JUMP;
      end
      ST_TRAP_REQ:  state_d = ST_TRAP_JUMP;
      ST_TRAP_JUMP: state_d = ST_IDLE;
      ST_MRET_JUMP: state_d = ST_IDLE;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
    accept_c = (state_q == ST_IDLE) && (state_d == ST_TRAP_REQ);
  end

  // Output decode from the upcoming state so outputs can be registered without extra latency
  always_comb begin
    req_d      = 1'b0;
    redirect_d = 1'b0;
    target_d   = '0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    fatal_d    = 1'b0;
    case (state_d)
      ST_TRAP_REQ: begin
        req_d   = 1'b1;
        flush_d = 1'b1;
        stall_d = 1'b1;
      end
      ST_TRAP_JUMP: begin
        redirect_d = 1'b1;
        target_d   = mtvec_i;
        stall_d    = 1'b1;
      end
      ST_MRET_JUMP: begin
        redirect_d = 1'b1;
        target_d   = mepc_i;
        flush_d    = 1'b1;
        stall_d    = 1'b1;
      end
      ST_HALT: begin
        fatal_d = 1'b1;
        stall_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered control outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_request_o <= 1'b0;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= '0;
      stall_o       <= 1'b0;
      flush_o       <= 1'b0;
      fatal_o       <= 1'b0;
    end else begin
      exc_request_o <= req_d;
      pc_redirect_o <= redirect_d;
      pc_target_o   <= target_d;
      stall_o       <= stall_d;
      flush_o       <= flush_d;
      fatal_o       <= fatal_d;
    end
  end

  // Latch cause/pc/info of an accepted trap; held until the next one
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_cause_o <= '0;
      exc_pc_o    <= '0;
      trap_info_o <= '0;
    end else if (accept_c) begin
      exc_cause_o <= enc_cause_c;
      exc_pc_o    <= pc_i;
      trap_info_o <= info_c;
    end
  end

  // in_trap tracks handler residency; trap counter counts TRAP_REQ cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_trap_q  <= 1'b0;
      trap_cnt_o <= '0;
    end else begin
      if (accept_c)
        in_trap_q <= 1'b1;
      else if (state_q == ST_IDLE && state_d == ST_MRET_JUMP)
        in_trap_q <= 1'b0;
      if (state_q == ST_TRAP_REQ)
        trap_cnt_o <= trap_cnt_o + TRAP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes expected requests/redirects,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_trap_sequencer;
  import riscV_unrn_pkg::*;

  // Narrow counter so the wrap boundary is reachable in a short run
  localparam int unsigned CW = 4;

  localparam exc_flags_t F_NONE  = 6'b000000;
  localparam exc_flags_t F_FMIS  = 6'b100000;
  localparam exc_flags_t F_ILL   = 6'b010000;
  localparam exc_flags_t F_EBRK  = 6'b001000;
  localparam exc_flags_t F_LMIS  = 6'b000100;
  localparam exc_flags_t F_SMIS  = 6'b000010;
  localparam exc_flags_t F_ECALL = 6'b000001;
  localparam logic [31:0] MTVEC  = 32'h0000_0200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [31:0]   pc = '0, instr = '0, mem_addr = '0, mtvec = MTVEC, mepc = '0;
  exc_flags_t    flags = F_NONE;
  logic          mret = 1'b0, mtime = 1'b0;
  logic          exc_request, pc_redirect, stall, flush, fatal;
  logic [31:0]   exc_cause, trap_info, exc_pc, pc_target;
  logic [CW-1:0] trap_cnt;

  typedef struct {
    logic        is_redir;
    int unsigned cyc;
    logic [31:0] cause;
    logic [31:0] pc;
    logic [31:0] info;
    logic [31:0] target;
    logic        flush;
  } exp_t;

  exp_t          expq[$];
  int            checks = 0;
  int            failures = 0;
  int unsigned   cyc = 0;
  logic [CW-1:0] exp_cnt = '0;

  trap_sequencer #(.TRAP_CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid),
    .pc_i          (pc),
    .instr_i       (instr),
    .exc_flags_i   (flags),
    .mem_addr_i    (mem_addr),
    .mret_i        (mret),
    .mtime_exc_i   (mtime),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .exc_request_o (exc_request),
    .exc_cause_o   (exc_cause),
    .trap_info_o   (trap_info),
    .exc_pc_o      (exc_pc),
    .pc_redirect_o (pc_redirect),
    .pc_target_o   (pc_target),
    .stall_o       (stall),
    .flush_o       (flush),
    .fatal_o       (fatal),
    .trap_cnt_o    (trap_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every request or redirect must match the oldest expectation
  always @(negedge clk) begin
    if (rst && (exc_request || pc_redirect)) begin
      if (expq.size() == 0) begin
        chk("unexpected_output", {30'd0, pc_redirect, exc_request}, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("kind_is_redirect", {31'd0, pc_redirect}, {31'd0, e.is_redir});
        chk("cycle", cyc, e.cyc);
        chk("stall", {31'd0, stall}, 32'd1);
        chk("flush", {31'd0, flush}, {31'd0, e.flush});
        if (e.is_redir) begin
          chk("pc_target", pc_target, e.target);
        end else begin
          chk("exc_cause", exc_cause, e.cause);
          chk("exc_pc", exc_pc, e.pc);
          chk("trap_info", trap_info, e.info);
        end
      end
    end
  end

  task automatic push_req(input logic [31:0] cause, input logic [31:0] epc,
                          input logic [31:0] info, input int unsigned at);
    exp_t e;
    e = '{is_redir: 1'b0, cyc: at, cause: cause, pc: epc, info: info, target: '0, flush: 1'b1};
    expq.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] target, input logic fl, input int unsigned at);
    exp_t e;
    e = '{is_redir: 1'b1, cyc: at, cause: '0, pc: '0, info: '0, target: target, flush: fl};
    expq.push_back(e);
  endtask

  // Present one instruction-cycle of inputs, then return inputs to quiet
  task automatic fire(input logic v, input exc_flags_t f, input logic m, input logic t,
                      input logic [31:0] p, input logic [31:0] ins, input logic [31:0] addr);
    valid = v; flags = f; mret = m; mtime = t; pc = p; instr = ins; mem_addr = addr;
    @(posedge clk); #1;
    valid = 1'b0; flags = F_NONE; mret = 1'b0; mtime = 1'b0;
  endtask

  task automatic do_trap(input exc_flags_t f, input logic t, input logic m,
                         input logic [31:0] p, input logic [31:0] ins, input logic [31:0] addr,
                         input logic [31:0] cause, input logic [31:0] info);
    push_req(cause, p, info, cyc + 1);
    push_redir(MTVEC, 1'b0, cyc + 2);
    fire(1'b1, f, m, t, p, ins, addr);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_cnt = exp_cnt + CW'(1);
  endtask

  task automatic do_mret(input logic [31:0] epc);
    mepc = epc;
    push_redir(epc, 1'b1, cyc + 1);
    fire(1'b1, F_NONE, 1'b1, 1'b0, epc - 32'd4, 32'h3020_0073, '0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #10;
    chk("rst_exc_request", {31'd0, exc_request}, 32'd0);
    chk("rst_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("rst_stall_flush_fatal", {29'd0, stall, flush, fatal}, 32'd0);
    chk("rst_cause", exc_cause, 32'd0);
    chk("rst_trap_cnt", 32'(trap_cnt), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    idle(2);

    // Illegal instruction, then return via MRET
    do_trap(F_ILL, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF, '0, CAUSE_ILLEGAL, 32'hFFFF_FFFF);
    chk("cnt_after_illegal", 32'(trap_cnt), 32'(exp_cnt));
    do_mret(32'h104);

    // Timer concurrent with ecall: timer wins, counter steps once
    do_trap(F_ECALL, 1'b1, 1'b0, 32'h300, '0, '0, M_TIMER_INT, 32'd0);
    chk("cnt_after_timer", 32'(trap_cnt), 32'(exp_cnt));
    do_mret(32'h304);

    // Priority ladder
    do_trap(6'b111111, 1'b0, 1'b0, 32'h400, 32'h1234, 32'h40, CAUSE_FETCH_MIS, 32'h400);
    do_mret(32'h404);
    do_trap(F_EBRK | F_LMIS, 1'b0, 1'b0, 32'h500, '0, 32'h51, CAUSE_EBREAK, 32'h500);
    do_mret(32'h504);
    do_trap(F_LMIS | F_SMIS | F_ECALL, 1'b0, 1'b0, 32'h540, '0, 32'hABC, CAUSE_LOAD_MIS, 32'hABC);
    do_mret(32'h544);
    do_trap(F_SMIS | F_ECALL, 1'b0, 1'b0, 32'h580, '0, 32'hDEF, CAUSE_STORE_MIS, 32'hDEF);
    do_mret(32'h584);
    do_trap(F_ECALL, 1'b0, 1'b0, 32'h5C0, '0, 32'h77, CAUSE_ECALL, 32'd0);
    do_mret(32'h5C4);

    // Exception concurrent with MRET: MRET discarded, exc_pc is the MRET's PC
    do_trap(F_ILL, 1'b0, 1'b1, 32'h600, 32'h3020_0073, '0, CAUSE_ILLEGAL, 32'h3020_0073);
    do_mret(32'h604);

    // Flags without valid are not events
    fire(1'b0, F_ILL, 1'b0, 1'b0, 32'h640, 32'h0, '0);
    idle(2);
    chk("cnt_after_priority", 32'(trap_cnt), 32'(exp_cnt));

    // Nested fault: timer ignored inside handler, load_mis halts
    do_trap(F_ECALL, 1'b0, 1'b0, 32'h700, '0, '0, CAUSE_ECALL, 32'd0);
    fire(1'b0, F_NONE, 1'b0, 1'b1, 32'h704, '0, '0);
    idle(2);
    fire(1'b1, F_LMIS, 1'b0, 1'b0, 32'h708, '0, 32'h55);
    @(negedge clk);
    chk("halt_fatal", {31'd0, fatal}, 32'd1);
    chk("halt_stall", {31'd0, stall}, 32'd1);
    chk("halt_req_redirect", {30'd0, exc_request, pc_redirect}, 32'd0);
    chk("halt_cause_held", exc_cause, CAUSE_ECALL);
    #1;
    fire(1'b1, F_ILL, 1'b1, 1'b1, 32'h70C, '0, '0);
    idle(3);
    chk("halt_sticky", {31'd0, fatal}, 32'd1);
    chk("halt_cnt", 32'(trap_cnt), 32'(exp_cnt));
    rst = 1'b0;
    #1;
    chk("halt_rst_fatal", {30'd0, fatal, stall}, 32'd0);
    chk("halt_rst_cnt", 32'(trap_cnt), 32'd0);
    exp_cnt = '0;
    idle(1);
    rst = 1'b1;
    idle(2);

    // Reset during TRAP_REQ aborts the sequence, no redirect afterwards
    push_req(CAUSE_ILLEGAL, 32'h800, 32'hDEAD_BEEF, cyc + 1);
    fire(1'b1, F_ILL, 1'b0, 1'b0, 32'h800, 32'hDEAD_BEEF, '0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", {26'd0, exc_request, pc_redirect, stall, flush, fatal, 1'b0}, 32'd0);
    chk("midrst_cause", exc_cause, 32'd0);
    chk("midrst_info", trap_info, 32'd0);
    chk("midrst_cnt", 32'(trap_cnt), 32'd0);
    idle(1);
    rst = 1'b1;
    idle(4);
    chk("midrst_cnt_after", 32'(trap_cnt), 32'd0);

    // Counter wrap: all-ones then back to zero
    for (int i = 0; i < 16; i++) begin
      do_trap(F_ECALL, 1'b0, 1'b0, 32'h1000 + 32'(i * 4), '0, '0, CAUSE_ECALL, 32'd0);
      chk("wrap_cnt", 32'(trap_cnt), 32'(exp_cnt));
      do_mret(32'h2000 + 32'(i * 4));
    end
    chk("wrap_final_zero", 32'(trap_cnt), 32'd0);

    idle(4);
    chk("queue_empty", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
